// File: rtl/full_add_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : full_add_pipe
//  Purpose  : Registered ripple-carry add/subtract unit built from per-bit
//             full-adder cells. Subtract reuses the same chain with
//             full-subtractor borrow semantics. One-cycle latency,
//             valid-qualified, no backpressure.
//  Options  : FULL_ADD_PIPE_OVF_EN - adds a registered signed-overflow
//             output (ovf) alongside sum.
//  Revision : 1.0 - initial release
// ============================================================================
module full_add_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef FULL_ADD_PIPE_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  localparam int MSB = WIDTH - 1;

  // Ripple chain: bit 0 takes cin as carry-in (add) or borrow-in (subtract).
  logic [WIDTH:0]   w_chain;
  logic [WIDTH-1:0] w_sum;

  assign w_chain[0] = cin;

  // One cell per bit. The sum/difference bit is a^b^c in both modes; the
  // borrow of a full subtractor is the majority of (~a, b, w), so inverting
  // a only on the carry path turns the adder cell into a subtractor cell.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      logic w_a_carry;
      assign w_a_carry      = a[i] ^ sub;
      assign w_sum[i]       = a[i] ^ b[i] ^ w_chain[i];
      assign w_chain[i+1]   = (w_a_carry & b[i])
                            | (w_a_carry & w_chain[i])
                            | (b[i]      & w_chain[i]);
    end
  endgenerate

`ifdef FULL_ADD_PIPE_OVF_EN
  // Signed overflow: operands agree (add) or differ (subtract) in sign and
  // the result's sign differs from operand A.
  logic w_ovf;
  assign w_ovf = sub ? ((a[MSB] != b[MSB]) & (w_sum[MSB] != a[MSB]))
                     : ((a[MSB] == b[MSB]) & (w_sum[MSB] != a[MSB]));
`else
  // No overflow detection is built in this configuration.
`endif

  logic [WIDTH-1:0] sum_d,       sum_q;
  logic             cout_d,      cout_q;
  logic             out_valid_d, out_valid_q;
`ifdef FULL_ADD_PIPE_OVF_EN
  logic             ovf_d,       ovf_q;
`endif

  // Next-state: load the new result only when in_valid, otherwise hold, so
  // X on the operands while idle never reaches the registers.
  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = 1'b0;
`ifdef FULL_ADD_PIPE_OVF_EN
    ovf_d       = ovf_q;
`endif
    if (in_valid) begin
      sum_d       = w_sum;
      cout_d      = w_chain[WIDTH];
      out_valid_d = 1'b1;
`ifdef FULL_ADD_PIPE_OVF_EN
      ovf_d       = w_ovf;
`endif
    end
  end

  // Result registers with asynchronous clear; reset drops any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef FULL_ADD_PIPE_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
`ifdef FULL_ADD_PIPE_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;
`ifdef FULL_ADD_PIPE_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_full_add_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_full_add_pipe
//  Purpose  : Self-checking bench for full_add_pipe (WIDTH=4) with a
//             queue-based scoreboard fed from an arithmetic reference model.
//             Honours FULL_ADD_PIPE_OVF_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_full_add_pipe;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         out_valid;
`ifdef FULL_ADD_PIPE_OVF_EN
  logic         ovf;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  full_add_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
`ifdef FULL_ADD_PIPE_OVF_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: integer add/subtract, borrow from an unsigned compare.
  function automatic exp_t model(input logic s, input logic [W-1:0] aa,
                                 input logic [W-1:0] bb, input logic c);
    exp_t e;
    int   ai, bi, ci, r;
    ai = int'(aa);
    bi = int'(bb);
    ci = c ? 1 : 0;
    if (!s) begin
      r      = ai + bi + ci;
      e.cout = (r >= (1 << W));
    end else begin
      r      = ai - bi - ci;
      e.cout = (ai < bi + ci);
    end
    e.sum = r[W-1:0];
    if (!s) e.ovf = (aa[W-1] == bb[W-1]) && (e.sum[W-1] != aa[W-1]);
    else    e.ovf = (aa[W-1] != bb[W-1]) && (e.sum[W-1] != aa[W-1]);
    return e;
  endfunction

  // Apply inputs; valid stimulus queues its expected result.
  task automatic drive(input logic v, input logic s, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic c);
    in_valid = v;
    sub      = s;
    a        = aa;
    b        = bb;
    cin      = c;
    if (v) sb.push_back(model(s, aa, bb, c));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ovf_bad(input exp_t e);
`ifdef FULL_ADD_PIPE_OVF_EN
    return (ovf !== e.ovf);
`else
    return (e.ovf === 1'bz);
`endif
  endfunction

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    checks++;
    if (sum !== '0 || cout !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL reset_init: got sum=%h cout=%b out_valid=%b, expected 0/0/0", sum, cout, out_valid);
    else passed++;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    drive(1'b1, 1'b0, 4'hF, 4'h0, 1'b0);
    tick();
    e = sb.pop_front();
    checks++;
    if (sum !== e.sum || sum !== 4'hF || cout !== e.cout || out_valid !== 1'b1)
      $display("FAIL reset_preload: got sum=%h cout=%b out_valid=%b, expected %h/%b/1", sum, cout, out_valid, e.sum, e.cout);
    else passed++;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sum !== '0 || cout !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL reset_async: got sum=%h cout=%b out_valid=%b, expected 0/0/0", sum, cout, out_valid);
    else passed++;
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sub_truth();
    logic [W-1:0] av [3] = '{4'h0, 4'h0, 4'h1};
    logic [W-1:0] bv [3] = '{4'h0, 4'h1, 4'h1};
    logic [W-1:0] sv [3] = '{4'h0, 4'hF, 4'h0};
    logic         cv [3] = '{1'b0, 1'b1, 1'b0};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, av[i], bv[i], 1'b0);
      tick();
      e = sb.pop_front();
      checks++;
      if (sum !== sv[i] || cout !== cv[i] || sum !== e.sum || cout !== e.cout || out_valid !== 1'b1)
        $display("FAIL sub_truth%0d: got sum=%h cout=%b out_valid=%b, expected %h/%b/1", i, sum, cout, out_valid, sv[i], cv[i]);
      else passed++;
    end
  endtask

  task automatic test_add_chain();
    exp_t e;
    drive(1'b1, 1'b0, 4'hF, 4'h0, 1'b1);
    tick();
    e = sb.pop_front();
    checks++;
    if (sum !== 4'h0 || cout !== 1'b1 || sum !== e.sum || cout !== e.cout || out_valid !== 1'b1)
      $display("FAIL add_chain0: got sum=%h cout=%b out_valid=%b, expected 0/1/1", sum, cout, out_valid);
    else passed++;
    drive(1'b1, 1'b0, 4'h7, 4'h8, 1'b0);
    tick();
    e = sb.pop_front();
    checks++;
    if (sum !== 4'hF || cout !== 1'b0 || sum !== e.sum || cout !== e.cout || out_valid !== 1'b1)
      $display("FAIL add_chain1: got sum=%h cout=%b out_valid=%b, expected f/0/1", sum, cout, out_valid);
    else passed++;
  endtask

  task automatic test_hold();
    exp_t e;
    drive(1'b1, 1'b0, 4'h2, 4'h3, 1'b0);
    tick();
    e = sb.pop_front();
    checks++;
    if (sum !== 4'h5 || sum !== e.sum || out_valid !== 1'b1)
      $display("FAIL hold_load: got sum=%h out_valid=%b, expected 5/1", sum, out_valid);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 4'hA, 4'hA, 1'b0);
      tick();
      checks++;
      if (sum !== 4'h5 || cout !== e.cout || out_valid !== 1'b0)
        $display("FAIL hold%0d: got sum=%h cout=%b out_valid=%b, expected 5/%b/0", i, sum, cout, out_valid, e.cout);
      else passed++;
    end
    // Unknown operands while idle must not disturb the held result.
    in_valid = 1'b0; sub = 1'bx; a = 'x; b = 'x; cin = 1'bx;
    tick();
    checks++;
    if (sum !== 4'h5 || cout !== e.cout || out_valid !== 1'b0)
      $display("FAIL hold_x: got sum=%h cout=%b out_valid=%b, expected 5/%b/0", sum, cout, out_valid, e.cout);
    else passed++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   errs = 0;
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int ai = 0; ai < (1 << W); ai++)
          for (int bi = 0; bi < (1 << W); bi++) begin
            drive(1'b1, s[0], ai[W-1:0], bi[W-1:0], c[0]);
            tick();
            if (sb.size() == 0) begin
              checks++;
              $display("FAIL b2b_empty: got empty scoreboard, expected an entry");
            end else begin
              e = sb.pop_front();
              checks++;
              if (sum !== e.sum || cout !== e.cout || out_valid !== 1'b1 || ovf_bad(e)) begin
                if (errs < 10)
                  $display("FAIL b2b sub=%0d cin=%0d a=%h b=%h: got sum=%h cout=%b out_valid=%b, expected %h/%b/1",
                           s, c, ai, bi, sum, cout, out_valid, e.sum, e.cout);
                errs++;
              end else passed++;
            end
          end
    drive(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_midstream_reset();
    exp_t e;
    drive(1'b1, 1'b0, 4'h6, 4'h3, 1'b0);
    tick();
    e = sb.pop_front();
    checks++;
    if (sum !== e.sum || cout !== e.cout || out_valid !== 1'b1)
      $display("FAIL mid_pre: got sum=%h cout=%b out_valid=%b, expected %h/%b/1", sum, cout, out_valid, e.sum, e.cout);
    else passed++;
    drive(1'b1, 1'b1, 4'h2, 4'h9, 1'b1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    tick();
    #2;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    checks++;
    if (sum !== '0 || cout !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL mid_discard: got sum=%h cout=%b out_valid=%b, expected 0/0/0", sum, cout, out_valid);
    else passed++;
  endtask

`ifdef FULL_ADD_PIPE_OVF_EN
  task automatic test_ovf();
    logic         sv [3] = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0] av [3] = '{4'h7, 4'h8, 4'h3};
    logic [W-1:0] bv [3] = '{4'h1, 4'h1, 4'h2};
    logic [W-1:0] rv [3] = '{4'h8, 4'h7, 4'h5};
    logic         ov [3] = '{1'b1, 1'b1, 1'b0};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, sv[i], av[i], bv[i], 1'b0);
      tick();
      e = sb.pop_front();
      checks++;
      if (sum !== rv[i] || ovf !== ov[i] || ovf !== e.ovf || out_valid !== 1'b1)
        $display("FAIL ovf%0d: got sum=%h ovf=%b out_valid=%b, expected %h/%b/1", i, sum, ovf, out_valid, rv[i], ov[i]);
      else passed++;
    end
    drive(1'b0, 1'b0, 4'hF, 4'hF, 1'b0);
    tick();
    checks++;
    if (ovf !== 1'b0 || sum !== 4'h5)
      $display("FAIL ovf_hold: got sum=%h ovf=%b, expected 5/0", sum, ovf);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_sub_truth();
    test_add_chain();
    test_hold();
    test_back_to_back();
    test_midstream_reset();
`ifdef FULL_ADD_PIPE_OVF_EN
    test_ovf();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
